leftshift_seq: RTL and testbench

Multi-cycle logical left shifter for the processor ALU/shift path. It is the left-direction counterpart of the existing single-stage right shifter. The block accepts a 32-bit operand and a 5-bit shift amount on a start pulse. It applies one power-of-two stage per cycle (16, 8, 4, 2, 1), then presents the result with a one-cycle done pulse. The multicycle control unit stalls on busy.

---
 rtl/leftshift_pkg.sv | 16 +
 rtl/leftshift_stage.sv | 45 ++++
 rtl/mux_2_1.sv | 15 +
 rtl/leftshift_seq.sv | 101 ++++++++++
 tb/tb_leftshift_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/leftshift_pkg.sv
// Shared constants and state encoding for the multi-cycle left shifter.
//   LS_WIDTH   : default operand/result width
//   LS_SHAMT_W : default shift-amount width (log2 of LS_WIDTH, one stage per bit)
//   state_t    : controller states IDLE / SHIFT / DONE
package leftshift_pkg;

  localparam int unsigned LS_WIDTH   = 32;
  localparam int unsigned LS_SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/leftshift_stage.sv
// One power-of-two stage of the left shifter (combinational).
//   en      : apply this stage (1) or pass number through (0)
//   k       : stage index; the stage moves the word by 2^k bits
//   rotate  : 1 = rotate-left (bits leaving the MSB wrap to bit 0), 0 = zero-fill shift
//   number  : input word
//   shifted : output word
// The per-bit enable uses mux_2_1 cells, same structure as the right-shift stage.
module leftshift_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned KW      = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1
) (
  input  logic             en,
  input  logic [KW-1:0]    k,
  input  logic             rotate,
  input  logic [WIDTH-1:0] number,
  output logic [WIDTH-1:0] shifted
);

  localparam int unsigned AMT_W = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] WIDTH_L = AMT_W'(WIDTH);

  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] moved;

  always_comb begin
    amt   = AMT_W'(1) << k;
    shl   = number << amt;
    // amt never exceeds WIDTH/2, so the wrap-around term is always a real shift
    rol   = shl | (number >> (WIDTH_L - amt));
    moved = rotate ? rol : shl;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2_1 u_mux (
      .a   (number[i]),
      .b   (moved[i]),
      .sel (en),
      .y   (shifted[i])
    );
  end

endmodule

// File: rtl/mux_2_1.sv
// Single-bit 2:1 multiplexer cell shared by the shifter stages.
//   a   : selected when sel=0
//   b   : selected when sel=1
//   sel : select
//   y   : result
module mux_2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/leftshift_seq.sv
// Multi-cycle logical left shifter: one power-of-two stage per cycle
// (2^(SHAMT_W-1) down to 1), fixed latency of SHAMT_W cycles from accept to done.
// Optional feature macro: LEFTSHIFT_ROTATE_EN -- when defined, a captured
// rotate=1 makes every stage a rotate-left; otherwise rotate is ignored.
//   clock   : clock, rising edge
//   reset_n : asynchronous active-low reset
//   start   : request pulse, accepted in IDLE or DONE
//   number  : operand, captured on accept
//   shamt   : shift amount, captured on accept
//   rotate  : rotate request, captured on accept
//   busy    : shift in progress
//   done    : one-cycle pulse when out is updated
//   out     : result, held until the next operation completes
module leftshift_seq
  import leftshift_pkg::*;
#(
  parameter int unsigned WIDTH   = LS_WIDTH,
  parameter int unsigned SHAMT_W = LS_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   number,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               rotate,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  localparam int unsigned KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [KW-1:0] K_FIRST = KW'(SHAMT_W - 1);

`ifdef LEFTSHIFT_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] shamt_q;
  logic               rot_q;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   stage_out;
  logic               rot_eff;
  logic               accept;

  assign rot_eff = rot_q & ROT_EN;
  assign accept  = start && (state == IDLE || state == DONE);
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);

  leftshift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .KW      (KW)
  ) u_stage (
    .en      (shamt_q[k]),
    .k       (k),
    .rotate  (rot_eff),
    .number  (work),
    .shifted (stage_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      work    <= '0;
      shamt_q <= '0;
      rot_q   <= 1'b0;
      k       <= K_FIRST;
      out     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            work    <= number;
            shamt_q <= shamt;
            rot_q   <= rotate;
            k       <= K_FIRST;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= stage_out;
          if (k == '0) begin
            out   <= stage_out;
            state <= DONE;
          end else begin
            k <= k - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leftshift_seq.sv
// Self-checking bench for leftshift_seq: scoreboard of expected results,
// fixed-latency and handshake checks, back-to-back, ignored starts, reset mid-shift.
module tb_leftshift_seq;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] number;
  logic [4:0]  shamt;
  logic        rotate;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] expq[$];
  logic [31:0] prev_out;

  leftshift_seq #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .number  (number),
    .shamt   (shamt),
    .rotate  (rotate),
    .busy    (busy),
    .done    (done),
    .out     (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] n, input logic [4:0] s, input logic r);
    logic [31:0] res;
    res = n << s;
`ifdef LEFTSHIFT_ROTATE_EN
    if (r) res = (n << s) | (n >> (6'd32 - {1'b0, s}));
`else
    if (r) res = n << s;
`endif
    return res;
  endfunction

  // Scoreboard consumer and output-stability monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) begin
        if (expq.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          logic [31:0] e;
          e = expq.pop_front();
          check("result", out, e);
          prev_out = e;
        end
      end else begin
        check("out_stable", out, prev_out);
      end
    end
  end

  task automatic start_op(input logic [31:0] n, input logic [4:0] s, input logic r);
    number = n;
    shamt  = s;
    rotate = r;
    start  = 1'b1;
    expq.push_back(model(n, s, r));
  endtask

  // Called with start already high; returns at the negedge of the DONE cycle.
  task automatic wait_done(input string tag, input bit junk);
    int unsigned cyc;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 0;
    while (1) begin
      @(posedge clock);
      cyc++;
      #1;
      if (junk && cyc == 1) begin
        start  = 1'b1;
        number = 32'hFFFF_0000;
        shamt  = 5'd7;
        rotate = 1'b1;
      end else if (junk && cyc == 2) begin
        start = 1'b0;
      end
      @(negedge clock);
      if (done) break;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (cyc > 20) begin
        check({tag, "_timeout"}, 32'(cyc), 32'd5);
        return;
      end
    end
    check({tag, "_latency"}, cyc, 32'd5);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    number   = '0;
    shamt    = '0;
    rotate   = 1'b0;
    prev_out = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", out, 32'd0);
    reset_n = 1'b1;

    @(negedge clock);
    start_op(32'h0000_0001, 5'd5, 1'b0);
    wait_done("shift5", 1'b0);

    @(negedge clock);
    start_op(32'hFFFF_FFFF, 5'd31, 1'b0);
    wait_done("shift31", 1'b0);

    @(negedge clock);
    start_op(32'h1234_5678, 5'd0, 1'b0);
    wait_done("shift0", 1'b0);

    // Back-to-back start in the DONE cycle, with a junk start while busy
    start_op(32'hA5A5_A5A5, 5'd4, 1'b0);
    wait_done("b2b", 1'b1);

    @(negedge clock);
    start_op(32'h8000_0001, 5'd1, 1'b1);
    wait_done("rot1", 1'b0);

    @(negedge clock);
    start_op(32'h1234_5678, 5'd12, 1'b1);
    wait_done("rot12", 1'b0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      start_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      wait_done("rand", 1'b0);
    end

    // Reset two cycles after accept: in-flight result is discarded
    @(negedge clock);
    start_op(32'hDEAD_BEEF, 5'd8, 1'b0);
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    void'(expq.pop_back());
    prev_out = '0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", out, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check("midrst_no_done", 32'(done), 32'd0);
    end

    start_op(32'h0000_00F0, 5'd3, 1'b0);
    wait_done("recover", 1'b0);
    @(negedge clock);
    check("queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
